// File: rtl/axis_dac_streamer.sv
// rtl/axis_dac_streamer.sv - byte-stream to 16-bit sample FIFO with rate-divided DAC playback
// Packs byte pairs little-endian, prefills, then replays one sample per RATE_DIV clocks.
module axis_dac_streamer #(
  parameter int FIFO_DEPTH = 1024,
  parameter int PREFILL    = 512,
  parameter int RATE_DIV   = 100,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int LW = AW + 1,
  localparam int CW = $clog2(RATE_DIV)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in_axis_tdata,
  input  logic          in_axis_tvalid,
  output logic          in_axis_tready,
  input  logic          in_axis_tlast,
  input  logic          in_axis_tuser,
  input  logic          enable,
  output logic [15:0]   dac_data,
  output logic          dac_strobe,
  output logic [LW-1:0] fifo_level,
  output logic [15:0]   underflow_count,
  output logic [15:0]   odd_frame_count,
  output logic          state_playing
);
  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_PLAY} state_e;

  state_e          state_q, state_d;
  logic            in_idle, in_play;
  logic [LW-1:0]   level_q, level_d;
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   div_q;
  logic            phase_q;
  logic [7:0]      lo_q;
  logic            tready_q, tready_d;
  logic [15:0]     dac_q;
  logic            strobe_q;
  logic [15:0]     under_q, odd_q;
  logic [15:0]     mem_q [FIFO_DEPTH];
  logic            tick, accept, push, pop, odd_ev, under_ev;
  logic            unused_tuser;

  assign unused_tuser = in_axis_tuser;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_FILL;
        ST_FILL: if (level_q >= LW'(PREFILL)) state_d = ST_PLAY;
        ST_PLAY: if (tick && level_q == '0) state_d = ST_FILL;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_idle       = (state_q == ST_IDLE);
    in_play       = (state_q == ST_PLAY);
    state_playing = in_play;
  end

  assign tick     = (div_q == CW'(RATE_DIV - 1));
  assign accept   = enable && in_axis_tvalid && tready_q;
  assign push     = accept && phase_q;
  assign odd_ev   = accept && !phase_q && in_axis_tlast;
  assign pop      = enable && in_play && tick && (level_q != '0);
  assign under_ev = enable && in_play && tick && (level_q == '0);

  always_comb begin
    level_d = level_q;
    if (!enable)           level_d = '0;
    else if (push && !pop) level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;
  end

  // tready looks at the post-update level so a registered grant can never overrun the FIFO
  assign tready_d = enable && (level_d != LW'(FIFO_DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q  <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      div_q    <= '0;
      phase_q  <= 1'b0;
      lo_q     <= '0;
      tready_q <= 1'b0;
      dac_q    <= '0;
      strobe_q <= 1'b0;
      under_q  <= '0;
      odd_q    <= '0;
    end else begin
      level_q  <= level_d;
      tready_q <= tready_d;
      if (!enable) begin
        wr_q     <= '0;
        rd_q     <= '0;
        div_q    <= '0;
        phase_q  <= 1'b0;
        dac_q    <= '0;
        strobe_q <= 1'b0;
      end else begin
        if (push) wr_q <= wr_q + 1'b1;
        if (pop) begin
          rd_q  <= rd_q + 1'b1;
          dac_q <= mem_q[rd_q];
        end
        if (accept) begin
          phase_q <= in_axis_tlast ? 1'b0 : !phase_q;
          if (!phase_q) lo_q <= in_axis_tdata;
        end
        div_q    <= (in_idle || tick) ? '0 : div_q + 1'b1;
        strobe_q <= in_play && tick;
      end
      if (under_ev && under_q != 16'hFFFF) under_q <= under_q + 16'd1;
      if (odd_ev && odd_q != 16'hFFFF)     odd_q   <= odd_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {in_axis_tdata, lo_q};
  end

  assign in_axis_tready  = tready_q;
  assign dac_data        = dac_q;
  assign dac_strobe      = strobe_q;
  assign fifo_level      = level_q;
  assign underflow_count = under_q;
  assign odd_frame_count = odd_q;
endmodule

// File: tb/tb_axis_dac_streamer.sv
// tb/tb_axis_dac_streamer.sv - scoreboard bench for axis_dac_streamer
module tb_axis_dac_streamer;
  localparam int DEPTH = 8;
  localparam int PRE   = 4;
  localparam int RDIV  = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int WAIT_LIMIT = 2000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [7:0]    tdata = 8'h00;
  logic          tvalid = 1'b0;
  logic          tlast = 1'b0;
  logic          tuser = 1'b0;
  logic          tready;
  logic [15:0]   dac_data;
  logic          dac_strobe;
  logic [LW-1:0] fifo_level;
  logic [15:0]   ucnt, ocnt;
  logic          playing;

  axis_dac_streamer #(.FIFO_DEPTH(DEPTH), .PREFILL(PRE), .RATE_DIV(RDIV)) dut (
    .clk(clk), .reset(reset),
    .in_axis_tdata(tdata), .in_axis_tvalid(tvalid), .in_axis_tready(tready),
    .in_axis_tlast(tlast), .in_axis_tuser(tuser),
    .enable(enable), .dac_data(dac_data), .dac_strobe(dac_strobe),
    .fifo_level(fifo_level), .underflow_count(ucnt), .odd_frame_count(ocnt),
    .state_playing(playing)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int stamp; logic [15:0] s; } ent_t;
  ent_t exp_q[$];
  logic [7:0] frame_q[$];

  int compared = 0, mismatched = 0;
  int odd_exp = 0, uf_exp = 0;
  int flush_edge = -1;
  bit mon_en = 1'b0;
  bit ph = 1'b0;
  logic [7:0]  lo_b = 8'h00;
  logic [15:0] last_val = 16'h0000;
  int last_strobe = -1;
  bit prev_pop = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference packing: pairs of bytes form a little-endian sample; a frame ending on an unpaired byte drops it
  task automatic model_byte(input logic [7:0] b, input bit last);
    ent_t e;
    if (!ph) begin
      if (last) odd_exp++;
      else begin lo_b = b; ph = 1'b1; end
    end else begin
      e.stamp = cyc + 1;
      e.s = {b, lo_b};
      exp_q.push_back(e);
      ph = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last, input int max_gap);
    int gap;
    int waitc;
    gap = $urandom_range(max_gap, 0);
    waitc = 0;
    repeat (gap) begin @(negedge clk); tvalid = 1'b0; end
    @(negedge clk);
    tdata = b; tlast = last; tvalid = 1'b1; tuser = 1'($urandom);
    while (!tready && waitc < WAIT_LIMIT) begin @(negedge clk); waitc++; end
    if (waitc >= WAIT_LIMIT) begin
      compared++; mismatched++;
      $display("FAIL tready_wait: got %0d cycles required < %0d", waitc, WAIT_LIMIT);
      tvalid = 1'b0;
    end else begin
      model_byte(b, last);
    end
  endtask

  task automatic send_frame_q(input int max_gap, input bit with_last);
    for (int i = 0; i < frame_q.size(); i++)
      send_byte(frame_q[i], with_last && (i == frame_q.size() - 1), max_gap);
  endtask

  task automatic rand_frame(input int nbytes);
    frame_q.delete();
    for (int i = 0; i < nbytes; i++) frame_q.push_back(8'($urandom));
  endtask

  task automatic end_stream();
    @(negedge clk);
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    tvalid = 1'b0; tlast = 1'b0;
    enable = 1'b0;
    flush_edge = cyc + 1;
    ph = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
  endtask

  initial begin : monitor
    int pend, lvl, avail;
    ent_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (cyc == flush_edge) begin
          check("flush_level", 32'(fifo_level), 0);
          check("flush_dac", 32'(dac_data), 0);
          check("flush_playing", 32'(playing), 0);
          check("flush_tready", 32'(tready), 0);
          check("flush_strobe", 32'(dac_strobe), 0);
          check("flush_ucnt", 32'(ucnt), 32'(uf_exp));
          check("flush_ocnt", 32'(ocnt), 32'(odd_exp));
          exp_q.delete();
          last_val = 16'h0000;
          last_strobe = -1;
          prev_pop = 1'b0;
        end else begin
          if (dac_strobe) begin
            if (prev_pop) check("tick_spacing", 32'(cyc - last_strobe), RDIV);
            avail = 0;
            foreach (exp_q[i]) if (exp_q[i].stamp < cyc) avail++;
            if (avail > 0) begin
              if (!prev_pop) check("prefill_before_play", 32'(avail >= PRE), 1);
              e = exp_q.pop_front();
              check("dac_sample", 32'(dac_data), 32'(e.s));
              last_val = e.s;
              prev_pop = 1'b1;
            end else begin
              uf_exp++;
              check("underflow_hold", 32'(dac_data), 32'(last_val));
              check("underflow_count", 32'(ucnt), 32'(uf_exp));
              prev_pop = 1'b0;
            end
            last_strobe = cyc;
          end
          pend = (exp_q.size() > 0 && exp_q[$].stamp > cyc) ? 1 : 0;
          lvl = exp_q.size() - pend;
          check("fifo_level", 32'(fifo_level), 32'(lvl));
          if (lvl == DEPTH) check("tready_when_full", 32'(tready), 0);
        end
      end
    end
  end

  initial begin : stim
    int waitc;
    repeat (3) @(negedge clk);
    check("rst_dac", 32'(dac_data), 0);
    check("rst_strobe", 32'(dac_strobe), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_ucnt", 32'(ucnt), 0);
    check("rst_ocnt", 32'(ocnt), 0);
    check("rst_playing", 32'(playing), 0);
    check("rst_tready", 32'(tready), 0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("idle_tready", 32'(tready), 0);
    enable = 1'b1;

    frame_q = '{8'h34, 8'h12, 8'h78, 8'h56};
    send_frame_q(0, 1'b1);
    frame_q = '{8'hAA, 8'hBB, 8'hCC};
    send_frame_q(0, 1'b1);
    frame_q = '{8'h01, 8'h02};
    send_frame_q(0, 1'b1);
    end_stream();
    repeat (40) @(negedge clk);
    check("odd_after_directed", 32'(ocnt), 1);

    for (int f = 0; f < 30; f++) begin
      rand_frame($urandom_range(12, 1));
      send_frame_q((f % 3 == 2) ? 12 : 0, 1'b1);
    end
    end_stream();
    repeat (30) @(negedge clk);

    rand_frame(2 * DEPTH);
    send_frame_q(0, 1'b1);
    rand_frame(3);
    send_frame_q(0, 1'b0);
    do_flush();

    for (int f = 0; f < 20; f++) begin
      rand_frame($urandom_range(9, 1));
      send_frame_q((f % 2 == 1) ? 8 : 0, 1'b1);
    end
    end_stream();
    repeat (30) @(negedge clk);
    check("odd_count_end", 32'(ocnt), 32'(odd_exp));
    check("underflow_count_end", 32'(ucnt), 32'(uf_exp));

    rand_frame(2 * DEPTH);
    send_frame_q(0, 1'b1);
    end_stream();
    waitc = 0;
    while (!playing && waitc < WAIT_LIMIT) begin @(negedge clk); waitc++; end
    check("reach_play", 32'(playing), 1);
    repeat (RDIV + 1) @(negedge clk);
    mon_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_dac", 32'(dac_data), 0);
    check("async_strobe", 32'(dac_strobe), 0);
    check("async_level", 32'(fifo_level), 0);
    check("async_ucnt", 32'(ucnt), 0);
    check("async_ocnt", 32'(ocnt), 0);
    check("async_playing", 32'(playing), 0);
    check("async_tready", 32'(tready), 0);
    @(negedge clk);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
